// File: rtl/usb_tx_sequencer_if.sv
// Byte-level link between the USB TX sequencer, its request source, the payload FIFO
// and the bit-level TX encoder. The master modport is the sequencer side.
interface usb_tx_sequencer_if;
  logic       send_data;
  logic       send_nak;
  logic       clear_toggle;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_read;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_eop;
  logic       eop_done;
  logic       tx_active;
  logic       data_toggle;

  modport master (
    input  send_data, send_nak, clear_toggle, fifo_empty, fifo_rdata, tx_ready, eop_done,
    output fifo_read, tx_byte, tx_valid, tx_eop, tx_active, data_toggle
  );

  modport slave (
    output send_data, send_nak, clear_toggle, fifo_empty, fifo_rdata, tx_ready, eop_done,
    input  fifo_read, tx_byte, tx_valid, tx_eop, tx_active, data_toggle
  );
endinterface

// File: rtl/usb_tx_sequencer.sv
// Sequences one USB device-to-host packet per request: SYNC, PID, payload, CRC16, EOP.
// Maintains the DATA0/DATA1 toggle and the reflected CRC16 over the payload bytes.
module usb_tx_sequencer #(
  parameter int unsigned PKT_BYTES = 4,
  parameter int unsigned CNT_W     = 7
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_tx_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_WAIT_EOP
  } state_t;

  localparam logic [7:0]       SYNC_BYTE = 8'h80;
  localparam logic [7:0]       PID_DATA0 = 8'hC3;
  localparam logic [7:0]       PID_DATA1 = 8'h4B;
  localparam logic [7:0]       PID_NAK   = 8'h5A;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PKT_BYTES);

  state_t           r_state, w_state_nx;
  logic [7:0]       r_tx_byte, w_tx_byte_nx;
  logic             r_tx_valid, w_tx_valid_nx;
  logic [15:0]      r_crc, w_crc_nx, w_crc_upd;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_kind_data, w_kind_data_nx;
  logic             r_toggle, w_toggle_nx;
  logic             w_xfer;
  logic             w_last;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++)
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  assign w_xfer    = r_tx_valid & bus.tx_ready;
  assign w_crc_upd = crc16_byte(r_crc, r_tx_byte);
  assign w_last    = (r_cnt + 1'b1) == LAST_CNT;

  assign bus.tx_byte     = r_tx_byte;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.tx_eop      = (r_state == S_EOP);
  assign bus.fifo_read   = (r_state == S_DATA) & w_xfer;
  assign bus.tx_active   = (r_state != S_IDLE);
  assign bus.data_toggle = r_toggle;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_tx_byte   <= '0;
      r_tx_valid  <= 1'b0;
      r_crc       <= '1;
      r_cnt       <= '0;
      r_kind_data <= 1'b0;
      r_toggle    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_tx_byte   <= w_tx_byte_nx;
      r_tx_valid  <= w_tx_valid_nx;
      r_crc       <= w_crc_nx;
      r_cnt       <= w_cnt_nx;
      r_kind_data <= w_kind_data_nx;
      r_toggle    <= w_toggle_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_tx_byte_nx   = r_tx_byte;
    w_tx_valid_nx  = r_tx_valid;
    w_crc_nx       = r_crc;
    w_cnt_nx       = r_cnt;
    w_kind_data_nx = r_kind_data;
    w_toggle_nx    = r_toggle;
    case (r_state)
      S_IDLE: begin
        if (bus.send_data || bus.send_nak) begin
          w_kind_data_nx = bus.send_data;
          w_state_nx     = S_SYNC;
          w_tx_byte_nx   = SYNC_BYTE;
          w_tx_valid_nx  = 1'b1;
          w_crc_nx       = '1;
          w_cnt_nx       = '0;
        end
      end
      S_SYNC: begin
        if (w_xfer) begin
          w_state_nx   = S_PID;
          w_tx_byte_nx = !r_kind_data ? PID_NAK : (r_toggle ? PID_DATA1 : PID_DATA0);
        end
      end
      S_PID: begin
        if (w_xfer) begin
          if (!r_kind_data) begin
            w_state_nx    = S_EOP;
            w_tx_valid_nx = 1'b0;
          end else if (PKT_BYTES != 0) begin
            w_state_nx    = S_DATA;
            w_tx_byte_nx  = bus.fifo_rdata;
            w_tx_valid_nx = !bus.fifo_empty;
          end else begin
            w_state_nx   = S_CRC_LO;
            w_tx_byte_nx = ~r_crc[7:0];
          end
        end
      end
      S_DATA: begin
        // The popped head is only visible a cycle later, so each byte is
        // reloaded from the show-ahead port once the FIFO reports non-empty.
        if (w_xfer) begin
          w_crc_nx      = w_crc_upd;
          w_cnt_nx      = r_cnt + 1'b1;
          w_tx_valid_nx = 1'b0;
          if (w_last) begin
            w_state_nx    = S_CRC_LO;
            w_tx_byte_nx  = ~w_crc_upd[7:0];
            w_tx_valid_nx = 1'b1;
          end
        end else if (!r_tx_valid && !bus.fifo_empty) begin
          w_tx_byte_nx  = bus.fifo_rdata;
          w_tx_valid_nx = 1'b1;
        end
      end
      S_CRC_LO: begin
        if (w_xfer) begin
          w_state_nx   = S_CRC_HI;
          w_tx_byte_nx = ~r_crc[15:8];
        end
      end
      S_CRC_HI: begin
        if (w_xfer) begin
          w_state_nx    = S_EOP;
          w_tx_valid_nx = 1'b0;
        end
      end
      S_EOP: w_state_nx = S_WAIT_EOP;
      S_WAIT_EOP: begin
        if (bus.eop_done) begin
          w_state_nx = S_IDLE;
          if (r_kind_data) w_toggle_nx = ~r_toggle;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (bus.clear_toggle) w_toggle_nx = 1'b0;
  end
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Randomized bench for usb_tx_sequencer: a FIFO/encoder environment plus a packet-level
// reference (byte list and bit-serial CRC16) built from the USB packet format.
module tb_usb_tx_sequencer;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  logic n_rst;
  usb_tx_sequencer_if bus ();
  usb_tx_sequencer_if bus0 ();

  usb_tx_sequencer #(.PKT_BYTES(NB), .CNT_W(7)) u_dut  (.clk(clk), .n_rst(n_rst), .bus(bus));
  usb_tx_sequencer #(.PKT_BYTES(0),  .CNT_W(7)) u_dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0));

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic [7:0]  fifo_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  obs0_q[$];
  logic [7:0]  exp_q[$];
  int unsigned obs_cyc[$];
  int unsigned rd_cnt = 0, eop_cnt = 0, rd0_cnt = 0, eop0_cnt = 0;
  bit          pop_pend = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          chk_payload = 1'b0;
  bit          model_tog = 1'b0;
  logic        p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0]  p_byte = '0;

  // FIFO and encoder-ready environment; updates just after each rising edge.
  initial begin
    bus.fifo_empty  = 1'b1;
    bus.fifo_rdata  = '0;
    bus.tx_ready    = 1'b1;
    bus0.fifo_empty = 1'b1;
    bus0.fifo_rdata = '0;
    bus0.tx_ready   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pend       = 1'b0;
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      bus.tx_ready   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (n_rst) begin
      if (p_valid && !p_ready) begin
        check_eq("hold_valid", 16'(bus.tx_valid), 16'd1);
        check_eq("hold_byte", 16'(bus.tx_byte), 16'(p_byte));
      end
      if (bus.fifo_read) begin
        rd_cnt++;
        pop_pend = 1'b1;
        check_eq("read_nonempty", 16'(bus.fifo_empty), 16'd0);
      end
      if (chk_payload && obs_q.size() >= 2 && obs_q.size() < 2 + NB && bus.fifo_empty)
        check_eq("valid_while_empty", 16'(bus.tx_valid), 16'd0);
      if (bus.tx_valid && bus.tx_ready) begin
        obs_q.push_back(bus.tx_byte);
        obs_cyc.push_back(cyc);
      end
      if (bus.tx_eop) eop_cnt++;
      p_valid = bus.tx_valid;
      p_ready = bus.tx_ready;
      p_byte  = bus.tx_byte;
      if (bus0.tx_valid && bus0.tx_ready) obs0_q.push_back(bus0.tx_byte);
      if (bus0.fifo_read) rd0_cnt++;
      if (bus0.tx_eop) eop0_cnt++;
    end else begin
      p_valid = 1'b0;
    end
  end

  // CRC16 (x^16+x^15+x^2+1) over the payload bit stream in wire order, shifted MSB-first;
  // the complemented register goes out MSb first, i.e. bit-reversed into LSb-first bytes.
  function automatic logic [15:0] crc_tail(input logic [7:0] pl[$]);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    foreach (pl[k])
      for (int i = 0; i < 8; i++) begin
        fb = pl[k][i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    for (int i = 0; i < 8; i++) begin
      r[i]     = ~c[15-i];
      r[8+i]   = ~c[7-i];
    end
    return r;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_eop(input int unsigned e0, input string tag);
    int unsigned n;
    n = 0;
    while (eop_cnt == e0 && n < 600) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_eop_seen"}, 16'(eop_cnt - e0), 16'd1);
  endtask

  task automatic finish_pkt(input int unsigned e0, input bit clr, input string tag);
    tick($urandom_range(0, 3));
    bus.eop_done     = 1'b1;
    bus.clear_toggle = clr;
    tick(1);
    bus.eop_done     = 1'b0;
    bus.clear_toggle = 1'b0;
    tick(1);
    check_eq({tag, "_active"}, 16'(bus.tx_active), 16'd0);
    check_eq({tag, "_eop_once"}, 16'(eop_cnt - e0), 16'd1);
  endtask

  task automatic do_nak();
    int unsigned e0, r0;
    rdy_rand    = 1'b0;
    chk_payload = 1'b0;
    tick(1);
    obs_q.delete();
    obs_cyc.delete();
    e0 = eop_cnt;
    r0 = rd_cnt;
    bus.send_nak = 1'b1;
    tick(1);
    bus.send_nak = 1'b0;
    wait_eop(e0, "nak");
    check_eq("nak_len", 16'(obs_q.size()), 16'd2);
    check_eq("nak_sync", 16'(obs_q[0]), 16'h80);
    check_eq("nak_pid", 16'(obs_q[1]), 16'h5A);
    check_eq("nak_consec", 16'(obs_cyc[1] - obs_cyc[0]), 16'd1);
    finish_pkt(e0, 1'b0, "nak");
    check_eq("nak_toggle", 16'(bus.data_toggle), 16'(model_tog));
    check_eq("nak_no_read", 16'(rd_cnt - r0), 16'd0);
  endtask

  task automatic do_data(input bit seq, input int unsigned gap, input bit rnd,
                         input bit both, input bit nak_mid, input bit clr);
    logic [7:0]  pl[$];
    logic [15:0] crc;
    int unsigned e0, r0, n;
    rdy_rand = rnd;
    for (int i = 0; i < int'(NB); i++) pl.push_back(seq ? 8'(i) : 8'($urandom));
    for (int i = 0; i < int'(NB); i++) if (gap == 0 || i < 2) fifo_q.push_back(pl[i]);
    tick(1);
    obs_q.delete();
    e0 = eop_cnt;
    r0 = rd_cnt;
    chk_payload   = 1'b1;
    bus.send_data = 1'b1;
    bus.send_nak  = both;
    tick(1);
    bus.send_data = 1'b0;
    bus.send_nak  = 1'b0;
    if (gap > 0) begin
      n = 0;
      while (obs_q.size() < 4 && n < 600) begin
        tick(1);
        n++;
      end
      if (nak_mid) begin
        bus.send_nak = 1'b1;
        tick(1);
        bus.send_nak = 1'b0;
        tick(gap - 1);
      end else begin
        tick(gap);
      end
      for (int i = 2; i < int'(NB); i++) fifo_q.push_back(pl[i]);
    end
    wait_eop(e0, "data");
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(model_tog ? 8'h4B : 8'hC3);
    foreach (pl[k]) exp_q.push_back(pl[k]);
    crc = crc_tail(pl);
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
    check_eq("data_len", 16'(obs_q.size()), 16'(exp_q.size()));
    foreach (exp_q[k]) check_eq("data_byte", 16'(obs_q[k]), 16'(exp_q[k]));
    check_eq("data_reads", 16'(rd_cnt - r0), 16'(NB));
    finish_pkt(e0, clr, "data");
    model_tog = clr ? 1'b0 : ~model_tog;
    check_eq("data_toggle", 16'(bus.data_toggle), 16'(model_tog));
    chk_payload = 1'b0;
  endtask

  initial begin
    int unsigned e0, n, g;
    n_rst             = 1'b0;
    bus.send_data     = 1'b0;
    bus.send_nak      = 1'b0;
    bus.clear_toggle  = 1'b0;
    bus.eop_done      = 1'b0;
    bus0.send_data    = 1'b0;
    bus0.send_nak     = 1'b0;
    bus0.clear_toggle = 1'b0;
    bus0.eop_done     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_byte", 16'(bus.tx_byte), 16'h00);
    check_eq("rst_valid", 16'(bus.tx_valid), 16'd0);
    check_eq("rst_eop", 16'(bus.tx_eop), 16'd0);
    check_eq("rst_read", 16'(bus.fifo_read), 16'd0);
    check_eq("rst_active", 16'(bus.tx_active), 16'd0);
    check_eq("rst_toggle", 16'(bus.data_toggle), 16'd0);
    check_eq("rst0_valid", 16'(bus0.tx_valid), 16'd0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    tick(2);

    do_nak();
    do_data(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_data(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_data(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_data(1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      g = ($urandom_range(0, 1) != 0) ? $urandom_range(6, 9) : 0;
      do_data(1'b0, g, 1'b1, 1'($urandom_range(0, 1)), g != 0, 1'b0);
    end
    do_data(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_data(1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b1);

    // Zero-length data packet on the PKT_BYTES=0 instance.
    obs0_q.delete();
    e0 = eop0_cnt;
    bus0.send_data = 1'b1;
    tick(1);
    bus0.send_data = 1'b0;
    n = 0;
    while (eop0_cnt == e0 && n < 100) begin
      tick(1);
      n++;
    end
    check_eq("zlp_eop", 16'(eop0_cnt - e0), 16'd1);
    bus0.eop_done = 1'b1;
    tick(1);
    bus0.eop_done = 1'b0;
    tick(1);
    exp_q.delete();
    check_eq("zlp_len", 16'(obs0_q.size()), 16'd4);
    check_eq("zlp_sync", 16'(obs0_q[0]), 16'h80);
    check_eq("zlp_pid", 16'(obs0_q[1]), 16'hC3);
    check_eq("zlp_crc", 16'({obs0_q[3], obs0_q[2]}), crc_tail(exp_q));
    check_eq("zlp_no_read", 16'(rd0_cnt), 16'd0);
    check_eq("zlp_toggle", 16'(bus0.data_toggle), 16'd1);

    // Asynchronous reset while payload is in flight.
    rdy_rand = 1'b0;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    tick(1);
    obs_q.delete();
    e0 = eop_cnt;
    bus.send_data = 1'b1;
    tick(1);
    bus.send_data = 1'b0;
    n = 0;
    while (obs_q.size() < 3 && n < 100) begin
      tick(1);
      n++;
    end
    #2 n_rst = 1'b0;
    #1;
    check_eq("arst_byte", 16'(bus.tx_byte), 16'h00);
    check_eq("arst_valid", 16'(bus.tx_valid), 16'd0);
    check_eq("arst_eop", 16'(bus.tx_eop), 16'd0);
    check_eq("arst_read", 16'(bus.fifo_read), 16'd0);
    check_eq("arst_active", 16'(bus.tx_active), 16'd0);
    check_eq("arst_toggle", 16'(bus.data_toggle), 16'd0);
    fifo_q.delete();
    tick(3);
    n_rst = 1'b1;
    tick(5);
    check_eq("arst_no_eop", 16'(eop_cnt - e0), 16'd0);
    model_tog = 1'b0;
    do_nak();
    do_data(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
- Sequences transmission of one USB device-to-host handshake or data packet per request from the receive protocol unit.
- Accepts one-cycle send_data / send_nak strobes.
- Emits SYNC, PID, payload and CRC16 bytes to the bit-level TX encoder over a valid/ready byte handshake, then requests EOP.
- Reads the payload from the show-ahead data FIFO, computes CRC16 and maintains the DATA0/DATA1 toggle.

Parameters:
PKT_BYTES, 4, payload bytes per data packet; legal range 0..64.
CNT_W, 7, width of the payload byte counter; must hold PKT_BYTES.

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
send_data  input  1  one-cycle request: transmit a data packet
send_nak  input  1  one-cycle request: transmit a NAK handshake
clear_toggle  input  1  forces data toggle to DATA0 (set-configuration / reset)
fifo_empty  input  1  data FIFO empty flag
fifo_rdata  input  8  show-ahead FIFO head byte; valid when fifo_empty=0
fifo_read  output  1  one-cycle pop of the FIFO head
tx_byte  output  8  byte to encoder, LSb transmitted first
tx_valid  output  1  tx_byte is valid
tx_ready  input  1  encoder accepts tx_byte this cycle when tx_valid=1
tx_eop  output  1  one-cycle EOP request to encoder
eop_done  input  1  one-cycle pulse: encoder finished driving EOP
tx_active  output  1  high whenever the state is not IDLE
data_toggle  output  1  current toggle: 0=DATA0, 1=DATA1

Behaviour:
- Reset: state IDLE; tx_byte=0x00, tx_valid=0, tx_eop=0, fifo_read=0, tx_active=0, data_toggle=0, CRC=0xFFFF, counter=0.
- Reset mid-packet aborts immediately. No EOP is issued and the toggle is cleared.
- "Transfer" means a cycle with tx_valid=1 and tx_ready=1. tx_byte and tx_valid are registered. tx_byte must stay stable while tx_valid=1 and tx_ready=0.
- States and transitions:
  - IDLE: send_data captures kind=DATA; otherwise send_nak captures kind=NAK. If both are set, send_data wins. Go to SYNC. tx_valid rises the cycle after the request, with tx_byte=0x80.
  - SYNC: on transfer, go to PID.
  - PID: tx_byte is 0xC3 (DATA0), 0x4B (DATA1) or 0x5A (NAK). On transfer: NAK goes to EOP. DATA goes to DATA if PKT_BYTES>0, else CRC_LO.
  - DATA: tx_byte=fifo_rdata. tx_valid=0 while fifo_empty=1 (stall, no timeout). On transfer: fifo_read=1 that cycle, CRC updated with the byte, counter increments. After the PKT_BYTES-th transfer, go to CRC_LO.
  - CRC_LO: tx_byte = ~crc[7:0]. On transfer, go to CRC_HI.
  - CRC_HI: tx_byte = ~crc[15:8]. On transfer, go to EOP.
  - EOP: tx_valid=0; tx_eop=1 for exactly one cycle; go to WAIT_EOP.
  - WAIT_EOP: on eop_done, go to IDLE. If kind=DATA, data_toggle flips on that same edge.
- CRC16:
  - Polynomial 0x8005, processed LSb-first (reflected form 0xA001).
  - Initialised to 0xFFFF on entry to SYNC.
  - Updated over payload bytes only, never over PID.
  - Complement is transmitted low byte first.
- send_data / send_nak arriving while state is not IDLE are ignored and not queued.
- clear_toggle forces data_toggle=0 in any state. If it coincides with the toggle flip in WAIT_EOP, clear_toggle wins.
- fifo_read never asserts outside DATA, and never asserts while fifo_empty=1.
- Counter wraps only through reset to 0 on SYNC entry. Overflow is impossible given the CNT_W rule.

Test Plan:
- NAK: pulse send_nak, tx_ready held 1 -> bytes 0x80,0x5A on consecutive cycles; tx_eop one cycle; after eop_done, tx_active=0 and data_toggle unchanged.
- Data with PKT_BYTES=4, FIFO holding 00,01,02,03, toggle=0 -> bytes 0x80,0xC3,00,01,02,03 then two CRC bytes matching the bench CRC16 model; exactly 4 fifo_read pulses; toggle=1 after eop_done. A second send_data sends PID 0x4B.
- Back-pressure: tx_ready toggles randomly, and FIFO is empty for 5 cycles mid-payload -> tx_byte stable while stalled; tx_valid=0 while empty; no fifo_read while empty; byte sequence identical to the unstalled case.
- Zero-length (PKT_BYTES=0) -> bytes 0x80,0xC3,0x00,0x00; no fifo_read.
- send_data and send_nak in the same cycle -> data packet sent. send_nak during payload -> ignored. clear_toggle in the eop_done cycle -> toggle=0.
- n_rst asserted during the DATA state -> all outputs 0 asynchronously; no tx_eop; the next send_nak transmits cleanly.
